// File: rtl/vga_timing_multi.sv
// Runtime-reprogrammable VGA timing generator with a shadow timing set that
// is committed atomically at the frame boundary.
module vga_timing_multi #(
  parameter int unsigned W     = 12,
  parameter int unsigned H_RES = 1024,
  parameter int unsigned H_SS  = 1032,
  parameter int unsigned H_SE  = 1176,
  parameter int unsigned H_TOT = 1344,
  parameter int unsigned V_RES = 768,
  parameter int unsigned V_SS  = 771,
  parameter int unsigned V_SE  = 777,
  parameter int unsigned V_TOT = 806,
  parameter bit          H_POL = 1'b0,
  parameter bit          V_POL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [3:0]   cfg_addr,
  input  logic [W-1:0] cfg_data,
  output logic         cfg_pending,
  output logic         cfg_error,
  output logic [W-1:0] hdata,
  output logic [W-1:0] vdata,
  output logic         hsync,
  output logic         vsync,
  output logic         blank,
  output logic         line_start,
  output logic         frame_start
);

  typedef struct packed {
    logic [W-1:0] h_res;
    logic [W-1:0] h_ss;
    logic [W-1:0] h_se;
    logic [W-1:0] h_tot;
    logic [W-1:0] v_res;
    logic [W-1:0] v_ss;
    logic [W-1:0] v_se;
    logic [W-1:0] v_tot;
    logic         h_pol;
    logic         v_pol;
  } timing_t;

  localparam timing_t RST_SET = '{
    h_res: W'(H_RES), h_ss: W'(H_SS), h_se: W'(H_SE), h_tot: W'(H_TOT),
    v_res: W'(V_RES), v_ss: W'(V_SS), v_se: W'(V_SE), v_tot: W'(V_TOT),
    h_pol: H_POL, v_pol: V_POL
  };

  timing_t      sh_q, sh_d, act_q, act_d;
  logic [W-1:0] h_q, h_d, v_q, v_d;
  logic         pend_q, pend_d, err_q, err_d;
  logic         run_q;

  logic h_last_c, v_last_c, apply_c, valid_c;
  logic hs_act_c, vs_act_c, blank_c;

  assign h_last_c = (h_q == (act_q.h_tot - W'(1)));
  assign v_last_c = (v_q == (act_q.v_tot - W'(1)));
  // Apply looks at the pending state from before any same-cycle commit.
  assign apply_c  = run_q & h_last_c & v_last_c & pend_q;
  assign valid_c  = (sh_q.h_res != '0) && (sh_q.h_res < sh_q.h_ss) &&
                    (sh_q.h_ss < sh_q.h_se) && (sh_q.h_se <= sh_q.h_tot) &&
                    (sh_q.v_res != '0) && (sh_q.v_res < sh_q.v_ss) &&
                    (sh_q.v_ss < sh_q.v_se) && (sh_q.v_se <= sh_q.v_tot);

  assign hs_act_c = (h_q >= act_q.h_ss) && (h_q < act_q.h_se);
  assign vs_act_c = (v_q >= act_q.v_ss) && (v_q < act_q.v_se);
  assign blank_c  = (h_q >= act_q.h_res) || (v_q >= act_q.v_res);

  // Next-state: counters, register-port writes, commit and frame-boundary apply.
  always_comb begin
    sh_d   = sh_q;
    act_d  = act_q;
    pend_d = pend_q;
    err_d  = 1'b0;
    h_d    = h_q;
    v_d    = v_q;
    if (run_q) begin
      if (h_last_c) begin
        h_d = '0;
        v_d = v_last_c ? '0 : v_q + W'(1);
      end else begin
        h_d = h_q + W'(1);
      end
    end
    if (apply_c) begin
      act_d  = sh_q;
      pend_d = 1'b0;
    end
    if (cfg_we) begin
      case (cfg_addr)
        4'd0: sh_d.h_res = cfg_data;
        4'd1: sh_d.h_ss  = cfg_data;
        4'd2: sh_d.h_se  = cfg_data;
        4'd3: sh_d.h_tot = cfg_data;
        4'd4: sh_d.v_res = cfg_data;
        4'd5: sh_d.v_ss  = cfg_data;
        4'd6: sh_d.v_se  = cfg_data;
        4'd7: sh_d.v_tot = cfg_data;
        4'd8: begin
          sh_d.h_pol = cfg_data[0];
          sh_d.v_pol = cfg_data[1];
        end
        4'd9: begin
          pend_d = valid_c;
          err_d  = ~valid_c;
        end
        default: ;
      endcase
    end
  end

  // State registers; run_q holds the counters at (0,0) for one cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= RST_SET;
      act_q  <= RST_SET;
      h_q    <= '0;
      v_q    <= '0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      act_q  <= act_d;
      h_q    <= h_d;
      v_q    <= v_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      run_q  <= 1'b1;
    end
  end

  // Registered video decode of the counters, one cycle behind them.
  always_ff @(posedge clk) begin
    if (rst || !run_q) begin
      hdata       <= '0;
      vdata       <= '0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      blank       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hdata       <= h_q;
      vdata       <= v_q;
      hsync       <= hs_act_c ? act_q.h_pol : ~act_q.h_pol;
      vsync       <= vs_act_c ? act_q.v_pol : ~act_q.v_pol;
      blank       <= blank_c;
      line_start  <= (h_q == '0);
      frame_start <= (h_q == '0) && (v_q == '0);
    end
  end

  assign cfg_pending = pend_q;
  assign cfg_error   = err_q;

endmodule
